// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : int_ctrl
// Purpose  : Prioritised four-line interrupt controller. Raw request lines are
//            synchronised, and their rising edges are latched as pending
//            requests. An enable mask gates which lines may be served. A
//            registered irq is raised with a stable handler vector and held
//            until acknowledged. In-service levels are tracked so that only a
//            strictly higher priority can nest. reti unwinds one level.
//            Line 1 (bit 0) has the highest priority.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous active-high reset, clears all state
//            int_in     - raw asynchronous request lines (bit 0 = line 1)
//            mask_we    - mask register load enable
//            mask_d     - new mask value (1 = line enabled)
//            mask_q     - current mask
//            irq        - registered interrupt request to the control unit
//            ack        - single-cycle acknowledge, honoured only while irq=1
//            vector     - handler address, valid while irq=1, else 0
//            reti       - single-cycle return-from-interrupt strobe
//            pending    - latched requests not yet acknowledged
//            in_service - levels currently being serviced
// Revision : 1.0 - initial release
// ============================================================================
module int_ctrl #(
    parameter int            AW   = 10,
    parameter logic [AW-1:0] VEC1 = 10'b1111111011,
    parameter logic [AW-1:0] VEC2 = 10'b1111111110,
    parameter logic [AW-1:0] VEC3 = 10'b1111111101,
    parameter logic [AW-1:0] VEC4 = 10'b1111111100
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    int_in,
    input  logic          mask_we,
    input  logic [3:0]    mask_d,
    output logic [3:0]    mask_q,
    output logic          irq,
    input  logic          ack,
    output logic [AW-1:0] vector,
    input  logic          reti,
    output logic [3:0]    pending,
    output logic [3:0]    in_service
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // Synchroniser chain plus a history flop for edge detection
    logic [3:0]    r_s1, r_s2, r_h;
    logic [3:0]    r_mask, r_pending, r_in_service;
    logic [1:0]    r_state, w_state_next;
    logic          r_irq, w_irq_next;
    logic [AW-1:0] r_vector, w_vector_next;
    logic [1:0]    r_win, w_win_next;

    logic [3:0]    w_rise, w_eligible, w_win_onehot, w_is_lowest;
    logic [1:0]    w_win_idx;
    logic [2:0]    w_cur;
    logic          w_qualify, w_ack_take;
    logic [AW-1:0] w_vec_sel;

    assign w_rise       = r_s2 & ~r_h;
    assign w_eligible   = r_pending & r_mask;
    assign w_win_onehot = 4'b0001 << r_win;
    // Two's-complement trick isolates the lowest set bit (highest priority level)
    assign w_is_lowest  = r_in_service & (~r_in_service + 4'd1);
    assign w_ack_take   = (r_state == S_REQ) && ack;

    // Lowest-index eligible request; descending scan so the lowest index wins
    always_comb begin
        w_win_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_eligible[i]) w_win_idx = 2'(i);
        end
    end

    // Current service level; 4 means nothing is in service
    always_comb begin
        w_cur = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (r_in_service[i]) w_cur = 3'(i);
        end
    end

    assign w_qualify = (|w_eligible) && ({1'b0, w_win_idx} < w_cur);

    always_comb begin
        case (w_win_idx)
            2'd0:    w_vec_sel = VEC1;
            2'd1:    w_vec_sel = VEC2;
            2'd2:    w_vec_sel = VEC3;
            default: w_vec_sel = VEC4;
        endcase
    end

    // Datapath: synchroniser, mask, pending and in-service tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1         <= '0;
            r_s2         <= '0;
            r_h          <= '0;
            r_mask       <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
        end else begin
            r_s1 <= int_in;
            r_s2 <= r_s1;
            r_h  <= r_s2;
            if (mask_we) r_mask <= mask_d;
            // A fresh rise on the line being acknowledged re-arms it
            r_pending <= (r_pending & ~(w_ack_take ? w_win_onehot : 4'b0000)) | w_rise;
            r_in_service <= (r_in_service & ~(reti ? w_is_lowest : 4'b0000))
                          | (w_ack_take ? w_win_onehot : 4'b0000);
        end
    end

    // FSM state register, together with the registered outputs it drives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_irq    <= 1'b0;
            r_vector <= '0;
            r_win    <= 2'd0;
        end else begin
            r_state  <= w_state_next;
            r_irq    <= w_irq_next;
            r_vector <= w_vector_next;
            r_win    <= w_win_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_qualify) w_state_next = S_REQ;
            S_REQ:   if (ack) w_state_next = S_HOLD;
            S_HOLD:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM output logic: vector and winner are frozen for the whole REQ phase
    always_comb begin
        w_irq_next    = r_irq;
        w_vector_next = r_vector;
        w_win_next    = r_win;
        case (r_state)
            S_IDLE: begin
                if (w_qualify) begin
                    w_irq_next    = 1'b1;
                    w_vector_next = w_vec_sel;
                    w_win_next    = w_win_idx;
                end
            end
            S_REQ: begin
                if (ack) begin
                    w_irq_next    = 1'b0;
                    w_vector_next = '0;
                end
            end
            default: begin
                // HOLD keeps irq low for one cycle so a request cannot be taken twice
                w_irq_next    = 1'b0;
                w_vector_next = '0;
            end
        endcase
    end

    assign mask_q     = r_mask;
    assign irq        = r_irq;
    assign vector     = r_vector;
    assign pending    = r_pending;
    assign in_service = r_in_service;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_ctrl
// Purpose  : Self-checking bench for int_ctrl. Directed scenarios followed by
//            random traffic, compared every cycle against a behavioural model
//            built from the controller's rules (edge history, priority by
//            lowest index, nesting by strict priority).
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    int_in, mask_d, mask_q, pending, in_service;
    logic          mask_we, irq, ack, reti;
    logic [AW-1:0] vector;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [3:0]    m_q1, m_q2, m_q3;   // int_in sampled at the last three edges
    logic [3:0]    m_pend, m_ins, m_mask;
    logic          m_irq;
    logic [AW-1:0] m_vec;
    int            m_win;
    bit            m_cool;

    int takes;

    int_ctrl #(.AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .int_in     (int_in),
        .mask_we    (mask_we),
        .mask_d     (mask_d),
        .mask_q     (mask_q),
        .irq        (irq),
        .ack        (ack),
        .vector     (vector),
        .reti       (reti),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    function automatic int lowest(input logic [3:0] b);
        for (int i = 0; i < 4; i++) if (b[i]) return i;
        return 4;
    endfunction

    function automatic logic [AW-1:0] vec_of(input int line_idx);
        case (line_idx)
            0:       return 10'b1111111011;
            1:       return 10'b1111111110;
            2:       return 10'b1111111101;
            default: return 10'b1111111100;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q1 = '0; m_q2 = '0; m_q3 = '0;
        m_pend = '0; m_ins = '0; m_mask = '0;
        m_irq = 1'b0; m_vec = '0; m_win = 0; m_cool = 1'b0;
    endtask

    // Advance one clock edge: predict the model, then compare all outputs
    task automatic step();
        logic [3:0]    rise, n_pend, n_ins, n_mask;
        logic          n_irq;
        logic [AW-1:0] n_vec;
        int            n_win, w, cur, lo;
        bit            n_cool, ack_take;

        // A rise is recognised two edges after it is first sampled
        rise     = m_q2 & ~m_q3;
        ack_take = m_irq && ack;
        n_pend   = m_pend;
        if (ack_take) n_pend[m_win] = 1'b0;
        n_pend = n_pend | rise;
        n_ins = m_ins;
        lo = lowest(m_ins);
        if (reti && lo < 4) n_ins[lo] = 1'b0;
        if (ack_take) n_ins[m_win] = 1'b1;
        w   = lowest(m_pend & m_mask);
        cur = lowest(m_ins);
        n_irq = m_irq; n_vec = m_vec; n_win = m_win; n_cool = m_cool;
        if (m_irq) begin
            if (ack) begin n_irq = 1'b0; n_vec = '0; n_cool = 1'b1; end
        end else if (m_cool) begin
            n_cool = 1'b0;
        end else if (w < 4 && w < cur) begin
            n_irq = 1'b1; n_win = w; n_vec = vec_of(w);
        end
        n_mask = mask_we ? mask_d : m_mask;

        @(posedge clk);
        #1;
        m_q3 = m_q2; m_q2 = m_q1; m_q1 = int_in;
        m_pend = n_pend; m_ins = n_ins; m_mask = n_mask;
        m_irq = n_irq; m_vec = n_vec; m_win = n_win; m_cool = n_cool;

        check("model_irq",        32'(irq),        32'(m_irq));
        check("model_vector",     32'(vector),     32'(m_vec));
        check("model_pending",    32'(pending),    32'(m_pend));
        check("model_in_service", 32'(in_service), 32'(m_ins));
        check("model_mask",       32'(mask_q),     32'(m_mask));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Asynchronous reset pulse between edges; outputs must clear at once
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_irq",        32'(irq),        32'h0);
        check("rst_vector",     32'(vector),     32'h0);
        check("rst_pending",    32'(pending),    32'h0);
        check("rst_in_service", 32'(in_service), 32'h0);
        check("rst_mask",       32'(mask_q),     32'h0);
        #1;
        reset = 1'b0;
    endtask

    task automatic load_mask(input logic [3:0] m);
        mask_we = 1'b1; mask_d = m;
        step();
        mask_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; int_in = '0; mask_we = 1'b0; mask_d = '0; ack = 1'b0; reti = 1'b0;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // 1: masked line still latches pending but never raises irq
        int_in = 4'b0001;
        steps(2);
        check("t1_pend_edge2", 32'(pending), 32'h0);
        step();
        check("t1_pend_edge3", 32'(pending), 32'h1);
        steps(3);
        check("t1_no_irq", 32'(irq), 32'h0);
        check("t1_mask", 32'(mask_q), 32'h0);

        // 2: basic request / ack / HOLD
        int_in = 4'b0000;
        do_reset();
        load_mask(4'b1111);
        int_in = 4'b0100;
        steps(3);
        check("t2_pend", 32'(pending), 32'h4);
        check("t2_irq_edge3", 32'(irq), 32'h0);
        step();
        check("t2_irq", 32'(irq), 32'h1);
        check("t2_vec", 32'(vector), 32'(10'b1111111101));
        steps(2);
        check("t2_irq_held", 32'(irq), 32'h1);
        ack = 1'b1; step(); ack = 1'b0;
        check("t2_ack_irq", 32'(irq), 32'h0);
        check("t2_ack_vec", 32'(vector), 32'h0);
        check("t2_ack_ins", 32'(in_service), 32'h4);
        check("t2_ack_pend", 32'(pending), 32'h0);
        steps(2);
        check("t2_after_irq", 32'(irq), 32'h0);

        // 3: higher priority nests
        int_in = 4'b0101;
        steps(4);
        check("t3_irq", 32'(irq), 32'h1);
        check("t3_vec", 32'(vector), 32'(10'b1111111011));
        ack = 1'b1; step(); ack = 1'b0;
        check("t3_ins", 32'(in_service), 32'h5);
        step();

        // 4: lower priority waits until fully unwound
        int_in = 4'b1101;
        steps(3);
        check("t4_pend", 32'(pending), 32'h8);
        steps(2);
        check("t4_no_irq", 32'(irq), 32'h0);
        reti = 1'b1; step(); reti = 1'b0;
        check("t4_reti1_ins", 32'(in_service), 32'h4);
        steps(2);
        check("t4_still_no_irq", 32'(irq), 32'h0);
        reti = 1'b1; step(); reti = 1'b0;
        check("t4_reti2_ins", 32'(in_service), 32'h0);
        step();
        check("t4_irq", 32'(irq), 32'h1);
        check("t4_vec", 32'(vector), 32'(10'b1111111100));
        ack = 1'b1; step(); ack = 1'b0;
        step();

        // 5: simultaneous rises, then ack and reti on one edge
        int_in = 4'b0000;
        reti = 1'b1; step(); reti = 1'b0;
        steps(2);
        int_in = 4'b1010;
        steps(3);
        check("t5_pend", 32'(pending), 32'ha);
        step();
        check("t5_vec_first", 32'(vector), 32'(10'b1111111110));
        ack = 1'b1; step(); ack = 1'b0;
        steps(2);
        check("t5_blocked", 32'(irq), 32'h0);
        int_in = 4'b1011;
        steps(4);
        check("t5_nest_vec", 32'(vector), 32'(10'b1111111011));
        ack = 1'b1; reti = 1'b1; step(); ack = 1'b0; reti = 1'b0;
        check("t5_ack_reti_ins", 32'(in_service), 32'h1);
        steps(2);
        reti = 1'b1; step(); reti = 1'b0;
        step();
        check("t5_vec_second", 32'(vector), 32'(10'b1111111100));
        ack = 1'b1; step(); ack = 1'b0;

        // 6: held level produces one request; reset while irq is high
        int_in = 4'b0000;
        do_reset();
        load_mask(4'b1111);
        steps(2);
        int_in = 4'b0010;
        takes = 0;
        for (int k = 0; k < 20; k++) begin
            ack = irq;
            if (irq) takes++;
            step();
        end
        ack = 1'b0;
        check("t6_one_take", 32'(takes), 32'h1);
        int_in = 4'b0011;
        steps(4);
        check("t6_irq_before_rst", 32'(irq), 32'h1);
        #3;
        do_reset();

        // Random traffic against the model
        load_mask(4'b1111);
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(3) == 0) int_in[b] = ~int_in[b];
            mask_we = ($urandom_range(15) == 0);
            mask_d  = 4'($urandom_range(15));
            ack     = irq ? ($urandom_range(1) == 1) : ($urandom_range(7) == 0);
            reti    = ($urandom_range(9) == 0);
            step();
        end
        mask_we = 1'b0; ack = 1'b0; reti = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Prioritised interrupt controller on the CPU side of the four interrupt lines.
- Takes four raw request lines and synchronises them.
- Latches rising edges as pending requests and applies an enable mask.
- Raises a registered irq to the CPU with a stable 10-bit handler vector, holding it until the control unit acknowledges.
- Tracks in-service levels so only a strictly higher priority can nest; reti unwinds one level.
- Priority order: line 1 (bit 0) highest, line 4 (bit 3) lowest.

Parameters:
- AW, 10, width of the program address / vector.
- VEC1, 10'b1111111011, handler address for line 1 (bit 0).
- VEC2, 10'b1111111110, handler address for line 2 (bit 1).
- VEC3, 10'b1111111101, handler address for line 3 (bit 2).
- VEC4, 10'b1111111100, handler address for line 4 (bit 3).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- int_in  in  4  raw asynchronous request lines; bit0 = line 1.
- mask_we  in  1  load enable for the mask register.
- mask_d  in  4  new mask value; 1 = line enabled.
- mask_q  out  4  current mask.
- irq  out  1  interrupt request to the control unit (registered).
- ack  in  1  single-cycle acknowledge from the control unit; sampled only while irq=1.
- vector  out  AW  handler address; valid while irq=1, 0 otherwise.
- reti  in  1  single-cycle return-from-interrupt strobe.
- pending  out  4  latched requests not yet acknowledged.
- in_service  out  4  levels currently being serviced.

Behaviour:
- Reset (asynchronous, immediate): irq=0, vector=0, pending=0, in_service=0, mask_q=0, synchroniser and edge-history flops=0, state=IDLE.
- Synchroniser: int_in passes through two flops (s1, s2) per bit, plus a history flop h.
- Edge detect: a rise is s2 & ~h. A rise sets pending[i] on the 3rd rising clk edge after int_in[i] goes high.
- A level held high sets pending only once. Pulses shorter than one clk period are not guaranteed to be captured.
- Mask: on mask_we at a rising edge, mask_q <= mask_d. Masking never clears pending; masked requests stay pending.
- Eligibility: eligible = pending & mask_q. w = lowest set index of eligible. cur = lowest set index of in_service (4 if none). A request qualifies when eligible != 0 and w < cur.
- FSM states: IDLE, REQ, HOLD.
  - IDLE: if a request qualifies, go to REQ on the next edge; irq <= 1; latch win <= w; vector <= VEC(w+1).
  - REQ: irq=1. Vector and win stay frozen regardless of new requests, mask writes or reti.
  - REQ with ack=1: pending[win] <= 0, in_service[win] <= 1, irq <= 0, vector <= 0, go to HOLD.
  - HOLD: one cycle with irq=0 so the CPU cannot double-take the same request; then go to IDLE.
- Latency: int_in rise to irq high = 4 rising edges (mask already enabled, nothing in service).
- ack outside REQ is ignored.
- reti: in_service loses its lowest set bit. reti with in_service=0 has no effect. reti is accepted in any state.
- Simultaneous events on one edge:
  - ack and reti: in_service_next = (in_service & ~lowest_bit) | onehot(win).
  - ack of line i and a new rise on line i: pending[i] stays 1 (the new request wins).
  - Rises on several lines: all pending bits set; the lowest index is served first.
  - mask_we and qualification evaluation: the old mask is used that cycle.
- Reset asserted during REQ: irq drops immediately and the request is lost (pending cleared).

Test Plan:
1. Reset, then mask_q=0; int_in=0001 rising -> pending=0001 after 3 edges; irq stays 0; mask_q reads 0000.
2. mask=1111; int_in[2] rises -> pending=0100 at edge 3, irq=1 and vector=10'b1111111101 at edge 4; ack for 1 cycle -> in_service=0100, pending=0000, irq=0 in the HOLD cycle and afterwards.
3. Nesting, part 1: with in_service=0100, int_in[0] rises -> irq, vector=10'b1111111011; ack -> in_service=0101.
4. Nesting, part 2: int_in[3] rises -> pending=1000, no irq; reti -> in_service=0100, still no irq; reti -> in_service=0000, then irq with vector=10'b1111111100.
5. Simultaneous: int_in[1] and int_in[3] rise together -> vector=10'b1111111110 first; after ack and reti -> vector=10'b1111111100. Separately, ack and reti asserted on the same edge -> in_service updated per the combined formula.
6. Held level and reset: int_in[1] held high for 20 cycles -> exactly one request. Asynchronous reset pulse while irq=1 -> irq, vector and pending read 0 before the next clk edge.
